// File: rtl/adc_spi_responder.sv
// ADC128S-style SPI responder: returns a 12-bit sample per 16-clock frame and latches the next channel from DIN.
// Optional build macro ADC_RESP_TEST_PATTERN_EN replaces the payload with {cur_chan, frame_cnt}.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [95:0] ch_data,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_saddr,
  output logic        adc_sdat,
  output logic        adc_sdat_oe,
  output logic [2:0]  cur_chan,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, saddr_sync;
  logic                   cs_q, sclk_q;
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;

  state_t      state, state_n;
  logic [15:0] shreg, shreg_n;
  logic [15:0] din, din_n;
  logic [4:0]  cnt, cnt_n;
  logic [2:0]  chan_n;
  logic        done_n, err_n, oe_n;
  logic [11:0] payload;

  logic cs_s, sclk_s, saddr_s;
  logic cs_fall, cs_rise, sclk_fall, sclk_rise;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign saddr_s   = saddr_sync[SYNC_STAGES-1];
  // A fall only counts once the chain holds real pin data and cs_n was seen high,
  // so a cs_n held low across reset cannot start a frame.
  assign cs_fall   = armed & cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_fall = sclk_q & ~sclk_s;
  assign sclk_rise = ~sclk_q & sclk_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync    <= '1;
      sclk_sync  <= '0;
      saddr_sync <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      fill       <= '0;
      armed      <= 1'b0;
    end else begin
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
      saddr_sync <= {saddr_sync[SYNC_STAGES-2:0], adc_saddr};
      cs_q       <= cs_s;
      sclk_q     <= sclk_s;
      fill       <= {fill[SYNC_STAGES-1:0], 1'b1};
      armed      <= armed | (fill[SYNC_STAGES] & cs_s);
    end
  end

`ifdef ADC_RESP_TEST_PATTERN_EN
  logic [8:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) frame_cnt <= '0;
    else if (done_n) frame_cnt <= frame_cnt + 9'd1;
  end

  assign payload = {cur_chan, frame_cnt};
`else
  assign payload = ch_data[12*int'(cur_chan) +: 12];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      din         <= '0;
      cnt         <= '0;
      cur_chan    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      adc_sdat_oe <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      din         <= din_n;
      cnt         <= cnt_n;
      cur_chan    <= chan_n;
      frame_done  <= done_n;
      frame_err   <= err_n;
      adc_sdat_oe <= oe_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    din_n   = din;
    cnt_n   = cnt;
    chan_n  = cur_chan;
    done_n  = 1'b0;
    err_n   = 1'b0;
    oe_n    = adc_sdat_oe;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          shreg_n = {4'b0000, payload};
          cnt_n   = '0;
          din_n   = '0;
          oe_n    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // cs_n rise wins over any sclk edge seen in the same clk
        if (cs_rise) begin
          err_n   = 1'b1;
          oe_n    = 1'b0;
          state_n = IDLE;
        end else if (sclk_fall) begin
          shreg_n = shreg << 1;
        end else if (sclk_rise) begin
          cnt_n = cnt + 5'd1;
          din_n = (din << 1) | {15'd0, saddr_s};
          if (cnt == 5'd15) begin
            chan_n  = din_n[13:11];
            done_n  = 1'b1;
            state_n = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          oe_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign adc_sdat = (state == SHIFT) & shreg[15];

endmodule
